// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - register bank behind the SPI slave; SPI_REGBANK_SHADOW_EN adds shadowed CTRL/CFG with APPLY
module spi_regbank #(
    parameter int                ADDR_W   = 3,
    parameter int                REG_W    = 8,
    parameter logic [REG_W-1:0]  CTRL_RST = '0,
    parameter logic [REG_W-1:0]  ID_VAL   = REG_W'(8'hA5)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [REG_W-1:0]    wr_data_i,
    input  logic                wr_vld_i,
    output logic [REG_W-1:0]    rd_data_o,
    output logic [7:0]          status_o,
    input  logic [5:0]          fastcmd_i,
    input  logic                fastcmd_vld_i,
    input  logic [REG_W-1:0]    event_i,
    output logic [REG_W-1:0]    ctrl_o,
    output logic [4*REG_W-1:0]  cfg_o,
    output logic                irq_o,
    output logic [7:0]          strobe_o
);

    localparam logic [5:0] FC_SOFT_RST = 6'h01;
    localparam logic [5:0] FC_CLR_IRQ  = 6'h02;
    localparam logic [5:0] FC_LOCK     = 6'h03;
    localparam logic [5:0] FC_UNLOCK   = 6'h04;
    localparam logic [5:0] FC_CLR_ERR  = 6'h05;

    // prog_* are the SPI-visible copies; without shadowing they drive the outputs directly
    logic [REG_W-1:0]   prog_ctrl_q, prog_ctrl_d;
    logic [REG_W-1:0]   mask_q, mask_d;
    logic [4*REG_W-1:0] prog_cfg_q, prog_cfg_d;
    logic [REG_W-1:0]   flags_q, flags_d;
    logic               locked_q, locked_d;
    logic               wr_err_q, wr_err_d;
    logic [REG_W-1:0]   rd_data_q, rd_data_d;
    logic               irq_q, irq_d;
    logic [7:0]         strobe_q, strobe_d;

    logic               addr_hi;
    logic [2:0]         addr_lo;
    logic [REG_W-1:0]   w1c;
    logic               set_err;
    logic               irq_pend;
    logic               fc_is;

    assign addr_hi  = (32'(reg_addr) >= 32'd8);
    assign addr_lo  = reg_addr[2:0];
    assign irq_pend = |(flags_q & mask_q);
    assign fc_is    = fastcmd_vld_i;
    assign status_o = {irq_pend, locked_q, wr_err_q, 5'b0};

    // Next-state of the bank: SPI write first, then fast command overrides on the same register
    always_comb begin
        prog_ctrl_d = prog_ctrl_q;
        mask_d      = mask_q;
        prog_cfg_d  = prog_cfg_q;
        locked_d    = locked_q;
        wr_err_d    = wr_err_q;
        w1c         = '0;
        set_err     = 1'b0;
        if (wr_vld_i) begin
            if (addr_hi) begin
                set_err = 1'b1;
            end else begin
                case (addr_lo)
                    3'd6: w1c = wr_data_i;
                    3'd7: set_err = 1'b1;
                    default: begin
                        // lock is checked against the pre-edge state, so a same-cycle LOCK doesn't block
                        if (locked_q) begin
                            set_err = 1'b1;
                        end else begin
                            case (addr_lo)
                                3'd0:    prog_ctrl_d = wr_data_i;
                                3'd1:    mask_d = wr_data_i;
                                3'd2:    prog_cfg_d[0*REG_W +: REG_W] = wr_data_i;
                                3'd3:    prog_cfg_d[1*REG_W +: REG_W] = wr_data_i;
                                3'd4:    prog_cfg_d[2*REG_W +: REG_W] = wr_data_i;
                                default: prog_cfg_d[3*REG_W +: REG_W] = wr_data_i;
                            endcase
                        end
                    end
                endcase
            end
        end
        // events always win over a same-cycle clear
        flags_d = (flags_q & ~w1c) | event_i;
        if (fc_is) begin
            case (fastcmd_i)
                FC_SOFT_RST: begin
                    prog_ctrl_d = CTRL_RST;
                    mask_d      = '0;
                    prog_cfg_d  = '0;
                end
                FC_CLR_IRQ: flags_d  = event_i;
                FC_LOCK:    locked_d = 1'b1;
                FC_UNLOCK:  locked_d = 1'b0;
                FC_CLR_ERR: wr_err_d = 1'b0;
                default: ;
            endcase
        end
        if (set_err) begin
            wr_err_d = 1'b1;
        end
    end

    // Registered read mux, strobe decode and interrupt output
    always_comb begin
        rd_data_d = '0;
        if (!addr_hi) begin
            case (addr_lo)
                3'd0:    rd_data_d = prog_ctrl_q;
                3'd1:    rd_data_d = mask_q;
                3'd2:    rd_data_d = prog_cfg_q[0*REG_W +: REG_W];
                3'd3:    rd_data_d = prog_cfg_q[1*REG_W +: REG_W];
                3'd4:    rd_data_d = prog_cfg_q[2*REG_W +: REG_W];
                3'd5:    rd_data_d = prog_cfg_q[3*REG_W +: REG_W];
                3'd6:    rd_data_d = flags_q;
                default: rd_data_d = ID_VAL;
            endcase
        end
        strobe_d = 8'd0;
        if (fc_is && fastcmd_i[5:3] == 3'b010) begin
            strobe_d = 8'd1 << fastcmd_i[2:0];
        end
        irq_d = irq_pend;
    end

    // Bank state flops
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prog_ctrl_q <= CTRL_RST;
            mask_q      <= '0;
            prog_cfg_q  <= '0;
            flags_q     <= '0;
            locked_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_data_q   <= '0;
            irq_q       <= 1'b0;
            strobe_q    <= 8'd0;
        end else begin
            prog_ctrl_q <= prog_ctrl_d;
            mask_q      <= mask_d;
            prog_cfg_q  <= prog_cfg_d;
            flags_q     <= flags_d;
            locked_q    <= locked_d;
            wr_err_q    <= wr_err_d;
            rd_data_q   <= rd_data_d;
            irq_q       <= irq_d;
            strobe_q    <= strobe_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign irq_o     = irq_q;
    assign strobe_o  = strobe_q;

`ifdef SPI_REGBANK_SHADOW_EN
    localparam logic [5:0] FC_APPLY = 6'h06;

    logic [REG_W-1:0]   act_ctrl_q, act_ctrl_d;
    logic [4*REG_W-1:0] act_cfg_q, act_cfg_d;

    // Active copies load the shadow only on APPLY; SOFT_RST clears them alongside the shadow
    always_comb begin
        act_ctrl_d = act_ctrl_q;
        act_cfg_d  = act_cfg_q;
        if (fc_is && fastcmd_i == FC_APPLY) begin
            act_ctrl_d = prog_ctrl_q;
            act_cfg_d  = prog_cfg_q;
        end else if (fc_is && fastcmd_i == FC_SOFT_RST) begin
            act_ctrl_d = CTRL_RST;
            act_cfg_d  = '0;
        end
    end

    // Active copy flops
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            act_ctrl_q <= CTRL_RST;
            act_cfg_q  <= '0;
        end else begin
            act_ctrl_q <= act_ctrl_d;
            act_cfg_q  <= act_cfg_d;
        end
    end

    assign ctrl_o = act_ctrl_q;
    assign cfg_o  = act_cfg_q;
`else
    assign ctrl_o = prog_ctrl_q;
    assign cfg_o  = prog_cfg_q;
`endif

endmodule

// File: tb/tb_spi_regbank.sv
// tb/tb_spi_regbank.sv - randomized bench for spi_regbank against an array-based register map model
module tb_spi_regbank;

    localparam int         ADDR_W   = 4;
    localparam int         REG_W    = 8;
    localparam logic [7:0] CTRL_RST = 8'h00;
    localparam logic [7:0] ID_VAL   = 8'hA5;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [7:0]  wr_data_i = '0;
    logic        wr_vld_i = 1'b0;
    logic [7:0]  rd_data_o;
    logic [7:0]  status_o;
    logic [5:0]  fastcmd_i = '0;
    logic        fastcmd_vld_i = 1'b0;
    logic [7:0]  event_i = '0;
    logic [7:0]  ctrl_o;
    logic [31:0] cfg_o;
    logic        irq_o;
    logic [7:0]  strobe_o;

    spi_regbank #(
        .ADDR_W   (ADDR_W),
        .REG_W    (REG_W),
        .CTRL_RST (CTRL_RST),
        .ID_VAL   (ID_VAL)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .reg_addr      (reg_addr),
        .wr_data_i     (wr_data_i),
        .wr_vld_i      (wr_vld_i),
        .rd_data_o     (rd_data_o),
        .status_o      (status_o),
        .fastcmd_i     (fastcmd_i),
        .fastcmd_vld_i (fastcmd_vld_i),
        .event_i       (event_i),
        .ctrl_o        (ctrl_o),
        .cfg_o         (cfg_o),
        .irq_o         (irq_o),
        .strobe_o      (strobe_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: m_reg indexed by register address (0 CTRL, 1 MASK, 2-5 CFG, 6 FLAGS, 7 ID)
    logic [7:0] m_reg [8];
    logic [7:0] m_act [5];
    bit         m_lock, m_err, m_irq;
    logic [7:0] m_rd, m_strobe;
    bit         shadow;

    logic [3:0] d_addr [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    logic [7:0] d_exp  [9] = '{CTRL_RST, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, ID_VAL, 8'h00};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_reg[0] = CTRL_RST;
        m_reg[7] = ID_VAL;
        for (int i = 0; i < 5; i++) m_act[i] = 8'h00;
        m_act[0] = CTRL_RST;
        m_lock = 0; m_err = 0; m_irq = 0;
        m_rd = 8'h00; m_strobe = 8'h00;
    endtask

    function automatic logic [7:0] exp_ctrl();
        return shadow ? m_act[0] : m_reg[0];
    endfunction

    function automatic logic [31:0] exp_cfg();
        return shadow ? {m_act[4], m_act[3], m_act[2], m_act[1]}
                      : {m_reg[5], m_reg[4], m_reg[3], m_reg[2]};
    endfunction

    function automatic logic [7:0] exp_status();
        return {|(m_reg[6] & m_reg[1]), m_lock, m_err, 5'b0};
    endfunction

    task automatic cyc(input logic [3:0] addr, input bit wv, input logic [7:0] wd,
                       input bit fv, input logic [5:0] fc, input logic [7:0] ev);
        logic [7:0] n_reg [8];
        logic [7:0] n_act [5];
        bit         n_lock, n_err, err_now;
        reg_addr = addr; wr_vld_i = wv; wr_data_i = wd;
        fastcmd_vld_i = fv; fastcmd_i = fc; event_i = ev;
        n_reg = m_reg; n_act = m_act; n_lock = m_lock; n_err = m_err; err_now = 0;
        m_rd     = (addr < 8) ? m_reg[addr[2:0]] : 8'h00;
        m_irq    = |(m_reg[6] & m_reg[1]);
        m_strobe = (fv && fc >= 6'h10 && fc <= 6'h17) ? (8'h01 << fc[2:0]) : 8'h00;
        if (wv) begin
            if (addr >= 8 || addr == 7) err_now = 1;
            else if (addr == 6)         n_reg[6] = m_reg[6] & ~wd;
            else if (m_lock)            err_now = 1;
            else                        n_reg[addr[2:0]] = wd;
        end
        n_reg[6] = n_reg[6] | ev;
        if (fv) begin
            if (fc == 6'h01) begin
                for (int i = 1; i < 6; i++) n_reg[i] = 8'h00;
                n_reg[0] = CTRL_RST;
                if (shadow) begin
                    for (int i = 1; i < 5; i++) n_act[i] = 8'h00;
                    n_act[0] = CTRL_RST;
                end
            end
            if (fc == 6'h02) n_reg[6] = ev;
            if (fc == 6'h03) n_lock = 1;
            if (fc == 6'h04) n_lock = 0;
            if (fc == 6'h05) n_err = 0;
            if (fc == 6'h06 && shadow) begin
                n_act[0] = m_reg[0];
                for (int i = 1; i < 5; i++) n_act[i] = m_reg[i + 1];
            end
        end
        if (err_now) n_err = 1;
        @(posedge clk);
        #1;
        m_reg = n_reg; m_act = n_act; m_lock = n_lock; m_err = n_err;
        chk("rd_data", rd_data_o, m_rd);
        chk("irq", irq_o, m_irq);
        chk("strobe", strobe_o, m_strobe);
        chk("ctrl", ctrl_o, exp_ctrl());
        chk("cfg", cfg_o, exp_cfg());
        chk("status", status_o, exp_status());
    endtask

    task automatic mid_reset();
        reg_addr = 4'd2; wr_vld_i = 1; wr_data_i = 8'h77;
        fastcmd_vld_i = 1; fastcmd_i = 6'h13; event_i = 8'hFF;
        #2 nrst = 0;
        #1;
        chk("arst_rd", rd_data_o, 8'h00);
        chk("arst_ctrl", ctrl_o, CTRL_RST);
        chk("arst_cfg", cfg_o, 32'h0);
        chk("arst_status", status_o, 8'h00);
        chk("arst_irq", irq_o, 1'b0);
        chk("arst_strobe", strobe_o, 8'h00);
        wr_vld_i = 0; fastcmd_vld_i = 0; event_i = 8'h00;
        @(posedge clk);
        #1 nrst = 1;
        model_reset();
    endtask

    initial begin
        logic [3:0] a;
        logic [5:0] fc;
`ifdef SPI_REGBANK_SHADOW_EN
        shadow = 1;
`else
        shadow = 0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1 nrst = 1;
        chk("reset_status", status_o, 8'h00);
        chk("reset_rd", rd_data_o, 8'h00);
        chk("reset_irq", irq_o, 1'b0);
        chk("reset_strobe", strobe_o, 8'h00);
        chk("reset_ctrl", ctrl_o, CTRL_RST);

        for (int k = 0; k < 9; k++) begin
            cyc(d_addr[k], 0, 8'h00, 0, 6'h00, 8'h00);
            chk("map_read", rd_data_o, d_exp[k]);
        end

        cyc(4'd4, 1, 8'h3C, 0, 6'h00, 8'h00);
        cyc(4'd4, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("cfg2_read", rd_data_o, 8'h3C);
        if (!shadow) chk("cfg2_out", cfg_o[23:16], 8'h3C);
        cyc(4'd7, 1, 8'h11, 0, 6'h00, 8'h00);
        chk("id_wr_err", status_o, 8'h20);
        cyc(4'd0, 0, 8'h00, 1, 6'h05, 8'h00);
        chk("clr_err", status_o, 8'h00);

        cyc(4'd1, 1, 8'h01, 0, 6'h00, 8'h00);
        cyc(4'd6, 0, 8'h00, 0, 6'h00, 8'h81);
        cyc(4'd6, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("flags_set", rd_data_o, 8'h81);
        chk("irq_set", irq_o, 1'b1);
        cyc(4'd6, 1, 8'h01, 0, 6'h00, 8'h01);
        cyc(4'd6, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("event_wins", rd_data_o, 8'h81);
        cyc(4'd6, 1, 8'h81, 0, 6'h00, 8'h00);
        cyc(4'd6, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("flags_clr", rd_data_o, 8'h00);
        chk("irq_clr", irq_o, 1'b0);

        cyc(4'd0, 0, 8'h00, 1, 6'h03, 8'h00);
        cyc(4'd0, 1, 8'hFF, 0, 6'h00, 8'h00);
        chk("locked_status", status_o, 8'h60);
        cyc(4'd0, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("locked_ctrl", rd_data_o, CTRL_RST);
        cyc(4'd0, 0, 8'h00, 1, 6'h04, 8'h00);
        cyc(4'd0, 1, 8'hFF, 0, 6'h00, 8'h00);
        cyc(4'd0, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("unlocked_ctrl", rd_data_o, 8'hFF);
        if (!shadow) chk("ctrl_out", ctrl_o, 8'hFF);
        cyc(4'd0, 1, 8'hAB, 1, 6'h01, 8'h00);
        cyc(4'd0, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("softrst_wins", rd_data_o, CTRL_RST);
        cyc(4'd0, 1, 8'h5A, 1, 6'h03, 8'h00);
        cyc(4'd0, 0, 8'h00, 1, 6'h04, 8'h00);
        chk("lock_old_state", rd_data_o, 8'h5A);
        cyc(4'd0, 0, 8'h00, 1, 6'h05, 8'h00);

        cyc(4'd0, 0, 8'h00, 1, 6'h13, 8'h00);
        chk("strobe_13", strobe_o, 8'h08);
        cyc(4'd0, 0, 8'h00, 0, 6'h00, 8'h00);
        chk("strobe_once", strobe_o, 8'h00);
        cyc(4'd0, 0, 8'h00, 1, 6'h2A, 8'h00);
        chk("cmd_2a_status", status_o, 8'h00);

        if (shadow) begin
            cyc(4'd2, 1, 8'h55, 0, 6'h00, 8'h00);
            cyc(4'd2, 0, 8'h00, 0, 6'h00, 8'h00);
            chk("shadow_read", rd_data_o, 8'h55);
            chk("shadow_hold", cfg_o[7:0], 8'h00);
            cyc(4'd2, 0, 8'h00, 1, 6'h06, 8'h00);
            chk("shadow_apply", cfg_o[7:0], 8'h55);
        end

        mid_reset();

        for (int i = 0; i < 1500; i++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) a[3] = 1'b0;
            case ($urandom_range(0, 8))
                0: fc = 6'h00;
                1: fc = 6'h01;
                2: fc = 6'h02;
                3: fc = 6'h03;
                4: fc = 6'h04;
                5: fc = 6'h05;
                6: fc = 6'h06;
                7: fc = 6'h10 + 6'($urandom_range(0, 7));
                default: fc = 6'($urandom);
            endcase
            cyc(a, bit'($urandom_range(0, 1)), 8'($urandom),
                ($urandom_range(0, 3) == 0), fc,
                8'($urandom & $urandom & $urandom));
            if (i % 500 == 250) mid_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
